aes_out_serializer: RTL and testbench
=====================================

Name: aes_out_serializer

Overview:
Downstream stage of AES_top. Captures each 128-bit result pulsed on AES_data_out / AES_data_out_valid into a small block FIFO. Streams each block out as WORD_W-bit words, most-significant word first, over a valid/ready handshake. Decouples the core's single-cycle result pulse from a narrower, back-pressured consumer such as a bus or UART bridge.

Parameters:
WORD_W, 32, output word width; legal values 32, 64, 128; NWORDS = 128/WORD_W.
DEPTH, 2, number of 128-bit blocks buffered; legal values 1..8.

Ports:
AES_clk  in  1  clock; all logic on rising edge.
AES_rst  in  1  reset, synchronous, active-high.
AES_data_out_valid  in  1  one-cycle pulse from AES_top; each high cycle carries one block.
AES_data_out  in  128  result block; sampled only when AES_data_out_valid = 1.
ser_data  out  WORD_W  current output word.
ser_valid  out  1  ser_data is valid.
ser_ready  in  1  consumer accepts the word when ser_valid & ser_ready.
ser_last  out  1  high with the final word (index NWORDS-1) of a block.
ser_ovf  out  1  sticky flag: a block was dropped because the FIFO was full.
fifo_level  out  4  number of blocks held, 0..DEPTH; includes the block currently being streamed.

Behaviour:
- Interface: one clock, AES_clk. Reset is synchronous and active-high (AES_rst).
- Reset: sampled at the clock edge. Forces ser_valid=0, ser_last=0, ser_ovf=0, fifo_level=0, ser_data=0, word index=0, rd/wr pointers=0. Reset mid-block discards all held blocks and the partial word position. Reset has priority over every other event in the same cycle.
- Write: at the edge where AES_data_out_valid=1 and the FIFO is not full (or a pop occurs in that same cycle), the block is written at wr_ptr and wr_ptr advances modulo DEPTH.
- Overflow: at the edge where AES_data_out_valid=1, the FIFO is full and no pop occurs, the block is dropped. ser_ovf is set to 1 and stays set until reset. FIFO contents are unchanged.
- Latency: a block written at edge N into an empty FIFO gives ser_valid=1 from cycle N+1. Its first word is present in that same cycle.
- Output word: ser_data = head_block[127 - idx*WORD_W -: WORD_W], where idx is the word index 0..NWORDS-1. Word 0 is bits [127:128-WORD_W].
- ser_valid = (fifo_level != 0). ser_data and ser_last are held stable while ser_valid=1 and ser_ready=0.
- Transfer (ser_valid & ser_ready at an edge): if idx < NWORDS-1, idx increments. If idx = NWORDS-1, idx returns to 0, the head block is popped and rd_ptr advances modulo DEPTH.
- ser_last = ser_valid & (idx == NWORDS-1). With WORD_W=128, ser_last = ser_valid on every word.
- Simultaneous pop and write:
  - fifo_level is unchanged.
  - When full, the incoming block is accepted, not dropped; the freed slot is reused in the same cycle.
- Simultaneous write and empty FIFO: no bypass. The data appears in the next cycle per the latency rule.
- ser_ready while ser_valid=0 is ignored.
- Back-to-back: with ser_ready held high, consecutive words of consecutive blocks stream with no bubble cycles.
- fifo_level is registered: +1 on write only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.

Optional Feature:
AES_OUT_DROP_CNT_EN
- Defined: adds output port drop_cnt, out, 8 bits. Increments on every dropped block and saturates at 255. Reset to 0 by AES_rst. ser_ovf = (drop_cnt != 0).
- Undefined: drop_cnt port and its counter are absent. ser_ovf alone records overflow as a sticky bit.

Test Plan:
1. Reset, then one pulse with AES_data_out=128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, ser_ready=1 -> starting one cycle after capture: ser_data = 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles; ser_last only on 70b4c55a; fifo_level 1 -> 0; ser_ovf=0.
2. ser_ready=0, DEPTH=2, three pulses with blocks A, B, C -> fifo_level=2, ser_ovf=1, drop_cnt=1 if enabled. Release ready -> exactly 8 words out (A then B), C never appears.
3. FIFO full, ser_ready=1, idx=3, a new pulse lands on the pop edge -> block accepted, fifo_level stays 2, ser_ovf stays 0, new block streams after the remaining block.
4. Random ser_ready toggling (e.g. pattern 1,0,0,1,1,0,1,...) during a block -> ser_data/ser_last stable while ready=0; word order preserved; no word skipped or duplicated.
5. Assert AES_rst after 2 words of a block are taken -> next cycle ser_valid=0, fifo_level=0, ser_ovf=0. A subsequent pulse streams from word 0.
6. WORD_W=128 build, 2 pulses with ser_ready=1 -> two single-word transfers, ser_last=1 on each, ser_data equals each full block.

Source files
------------

// File: rtl/aes_out_serializer.sv
// Buffers 128-bit AES result pulses in a small block FIFO and streams each block out MSW-first as WORD_W-bit words.
// Optional feature macro: AES_OUT_DROP_CNT_EN adds an 8-bit saturating drop counter (drop_cnt) that also drives ser_ovf.
module aes_out_serializer #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              AES_data_out_valid,
    input  logic [127:0]      AES_data_out,
    output logic [WORD_W-1:0] ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              ser_ovf,
`ifdef AES_OUT_DROP_CNT_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic [3:0]        fifo_level
);

    localparam int NWORDS = 128 / WORD_W;
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    logic [127:0]  mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    level_q, level_d;
    logic [127:0]  headBlock;
    logic [127:0]  headShifted;
    logic          full;
    logic          xfer;
    logic          pop;
    logic          wrEn;
    logic          drop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop on the same edge frees a slot, so a full FIFO still accepts the incoming block.
    always_comb begin
        ser_valid = (level_q != 4'd0);
        full      = (level_q == 4'(DEPTH));
        xfer      = ser_valid & ser_ready;
        pop       = xfer & (idx_q == LAST_IDX);
        wrEn      = AES_data_out_valid & (~full | pop);
        drop      = AES_data_out_valid & full & ~pop;

        wrPtr_d = wrEn ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = pop ? nextPtr(rdPtr_q) : rdPtr_q;

        idx_d = idx_q;
        if (xfer) begin
            idx_d = pop ? '0 : idx_q + 1'b1;
        end

        level_d = level_q;
        case ({wrEn, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        headBlock   = mem_q[rdPtr_q];
        headShifted = headBlock << (32'(idx_q) * WORD_W);
        ser_data    = ser_valid ? headShifted[127 -: WORD_W] : '0;
        ser_last    = ser_valid & (idx_q == LAST_IDX);
        fifo_level  = level_q;
    end

    always_ff @(posedge AES_clk) begin
        if (!AES_rst && wrEn) begin
            mem_q[wrPtr_q] <= AES_data_out;
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            idx_q   <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            idx_q   <= idx_d;
            level_q <= level_d;
        end
    end

`ifdef AES_OUT_DROP_CNT_EN
    logic [7:0] dropCnt_q, dropCnt_d;

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (drop && dropCnt_q != 8'hFF) begin
            dropCnt_d = dropCnt_q + 8'd1;
        end
        drop_cnt = dropCnt_q;
        ser_ovf  = (dropCnt_q != 8'd0);
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            dropCnt_q <= '0;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end
`else
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d   = ovf_q | drop;
        ser_ovf = ovf_q;
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer: a block-level reference pushes expected words, a negedge monitor pops and compares them.
// Honours AES_OUT_DROP_CNT_EN when the design is built with it.
module tb_aes_out_serializer;

    parameter int WORD_W = 32;
    parameter int DEPTH  = 2;
    localparam int NWORDS = 128 / WORD_W;

    typedef struct {
        logic [WORD_W-1:0] data;
        bit                last;
    } expWord_t;

    logic              AES_clk = 1'b0;
    logic              AES_rst = 1'b1;
    logic              AES_data_out_valid = 1'b0;
    logic [127:0]      AES_data_out = '0;
    logic [WORD_W-1:0] ser_data;
    logic              ser_valid;
    logic              ser_ready = 1'b0;
    logic              ser_last;
    logic              ser_ovf;
    logic [3:0]        fifo_level;
`ifdef AES_OUT_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    int       errors = 0;
    int       checks = 0;
    bit       started = 0;
    expWord_t expQ[$];
    int       held = 0;
    int       taken = 0;
    bit       mOvf = 0;
    int       mDrop = 0;

    aes_out_serializer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .AES_clk            (AES_clk),
        .AES_rst            (AES_rst),
        .AES_data_out_valid (AES_data_out_valid),
        .AES_data_out       (AES_data_out),
        .ser_data           (ser_data),
        .ser_valid          (ser_valid),
        .ser_ready          (ser_ready),
        .ser_last           (ser_last),
        .ser_ovf            (ser_ovf),
`ifdef AES_OUT_DROP_CNT_EN
        .drop_cnt           (drop_cnt),
`endif
        .fifo_level         (fifo_level)
    );

    always #5 AES_clk = ~AES_clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a block FIFO of capacity DEPTH, with each accepted block queued as its NWORDS words.
    always @(posedge AES_clk) begin
        bit popNow;
        bit xferNow;
        logic [127:0] blk;
        if (AES_rst) begin
            expQ.delete();
            held  = 0;
            taken = 0;
            mOvf  = 0;
            mDrop = 0;
        end else begin
            xferNow = (held > 0) && ser_ready;
            popNow  = xferNow && (taken == NWORDS - 1);
            if (AES_data_out_valid) begin
                if (held < DEPTH || popNow) begin
                    blk = AES_data_out;
                    for (int w = 0; w < NWORDS; w++) begin
                        expWord_t e;
                        e.data = WORD_W'(blk >> ((NWORDS - 1 - w) * WORD_W));
                        e.last = (w == NWORDS - 1);
                        expQ.push_back(e);
                    end
                    held++;
                end else begin
                    mOvf = 1;
                    if (mDrop < 255) mDrop++;
                end
            end
            if (xferNow) begin
                if (popNow) begin
                    held--;
                    taken = 0;
                end else begin
                    taken++;
                end
            end
        end
    end

    // Monitor: compares what the DUT presents against the head of the expected word queue.
    always @(negedge AES_clk) begin
        if (started) begin
            checkOutput("ser_valid", 128'(ser_valid), 128'(expQ.size() != 0));
            checkOutput("fifo_level", 128'(fifo_level), 128'((expQ.size() + NWORDS - 1) / NWORDS));
            checkOutput("ser_ovf", 128'(ser_ovf), 128'(mOvf));
`ifdef AES_OUT_DROP_CNT_EN
            checkOutput("drop_cnt", 128'(drop_cnt), 128'(mDrop));
`endif
            if (!ser_valid) begin
                checkOutput("ser_last_idle", 128'(ser_last), 128'(0));
            end else if (expQ.size() != 0) begin
                checkOutput("ser_data", 128'(ser_data), 128'(expQ[0].data));
                checkOutput("ser_last", 128'(ser_last), 128'(expQ[0].last));
                if (ser_ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input bit valid, input logic [127:0] data, input bit ready);
        AES_data_out_valid = valid;
        AES_data_out       = data;
        ser_ready          = ready;
        @(posedge AES_clk);
        #1;
    endtask

    task automatic applyReset();
        AES_rst = 1'b1;
        applyStimulus(0, '0, 0);
        AES_rst = 1'b0;
        started = 1;
        checkOutput("rst_valid", 128'(ser_valid), 128'(0));
        checkOutput("rst_level", 128'(fifo_level), 128'(0));
        checkOutput("rst_ovf", 128'(ser_ovf), 128'(0));
        checkOutput("rst_data", 128'(ser_data), 128'(0));
        checkOutput("rst_last", 128'(ser_last), 128'(0));
    endtask

    function automatic logic [127:0] randBlock();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 2000) begin
            applyStimulus(0, '0, 1);
            n++;
        end
        checkOutput("drain_empty", 128'(expQ.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] kv;
        logic [127:0] blkD;

        // Known vector, streamed with ready held high.
        applyReset();
        kv = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        applyStimulus(1, kv, 1);
        checkOutput("t1_first_word", 128'(ser_data), 128'(kv[127 -: WORD_W]));
        checkOutput("t1_level", 128'(fifo_level), 128'(1));
        drain();
        checkOutput("t1_level_end", 128'(fifo_level), 128'(0));

        // Overflow: DEPTH+1 blocks while stalled, the last one is dropped.
        applyReset();
        for (int i = 0; i <= DEPTH; i++) applyStimulus(1, randBlock(), 0);
        checkOutput("t2_level_full", 128'(fifo_level), 128'(DEPTH));
        checkOutput("t2_ovf", 128'(ser_ovf), 128'(1));
        drain();
        checkOutput("t2_ovf_sticky", 128'(ser_ovf), 128'(1));

        // Full FIFO, new block lands exactly on the pop edge.
        applyReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, randBlock(), 0);
        for (int i = 0; i < NWORDS - 1; i++) applyStimulus(0, '0, 1);
        applyStimulus(1, randBlock(), 1);
        checkOutput("t3_level", 128'(fifo_level), 128'(DEPTH));
        checkOutput("t3_ovf", 128'(ser_ovf), 128'(0));
        drain();

        // Random ready toggling during one block.
        applyReset();
        applyStimulus(1, randBlock(), 0);
        for (int i = 0; i < 4 * NWORDS; i++) applyStimulus(0, '0, 1'($urandom_range(0, 1)));
        drain();

        // Reset mid-block after two transfers, with the overflow flag set.
        applyReset();
        for (int i = 0; i <= DEPTH; i++) applyStimulus(1, randBlock(), 0);
        applyStimulus(0, '0, 1);
        applyStimulus(0, '0, 1);
        applyReset();
        blkD = randBlock();
        applyStimulus(1, blkD, 0);
        checkOutput("t5_word0", 128'(ser_data), 128'(blkD[127 -: WORD_W]));
        drain();

        // Randomized traffic with random back-pressure.
        applyReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 2) == 0), randBlock(), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Back-to-back blocks with ready held high.
        for (int i = 0; i < 3; i++) applyStimulus(1, randBlock(), 1);
        drain();

        started = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
